uart_rx_deframer: RTL and testbench

//  Serial UART receiver that undoes the Framer: samples rxd, checks the frame and returns the data byte.

---
 rtl/uart_rx_deframer.sv | 167 ++++++++++++++++
 tb/tb_uart_rx_deframer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_deframer.sv
// rtl/uart_rx_deframer.sv - oversampled UART receiver returning one data byte per frame with parity/stop error flags
module uart_rx_deframer #(
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sample_tick,
    input  logic       rx_en,
    input  logic       rxd,
    input  logic       dL,
    input  logic [1:0] p,
    input  logic       s,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] MID_TICK  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] LAST_TICK = TW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2, DONE} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs;
    logic [TW-1:0]          tick_cnt;
    logic [2:0]             bit_cnt;
    logic [7:0]             shift_q;
    logic                   ones_q;
    logic                   par_flag;
    logic                   frm_flag;
    logic                   cfg_dl;
    logic [1:0]             cfg_p;
    logic                   cfg_s;
    logic                   counting;
    logic                   sample_now;

    assign rxs = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
        end
    end

    // START samples at half a bit so every later sample (a full bit on) lands mid-bit.
    always_comb begin
        counting   = 1'b0;
        sample_now = 1'b0;
        if (state == START || state == DATA || state == PARITY ||
            state == STOP1 || state == STOP2) begin
            counting = 1'b1;
        end
        if (sample_tick && counting) begin
            sample_now = (state == START) ? (tick_cnt == MID_TICK) : (tick_cnt == LAST_TICK);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            shift_q    <= '0;
            ones_q     <= 1'b0;
            par_flag   <= 1'b0;
            frm_flag   <= 1'b0;
            cfg_dl     <= 1'b0;
            cfg_p      <= 2'b00;
            cfg_s      <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (!rx_en) begin
                state    <= IDLE;
                busy     <= 1'b0;
                tick_cnt <= '0;
            end else begin
                if (sample_tick && counting) begin
                    tick_cnt <= sample_now ? '0 : tick_cnt + 1'b1;
                end
                case (state)
                    IDLE: begin
                        if (sample_tick && !rxs) begin
                            state    <= START;
                            busy     <= 1'b1;
                            tick_cnt <= '0;
                            bit_cnt  <= '0;
                            shift_q  <= '0;
                            ones_q   <= 1'b0;
                            par_flag <= 1'b0;
                            frm_flag <= 1'b0;
                            cfg_dl   <= dL;
                            cfg_p    <= p;
                            cfg_s    <= s;
                        end
                    end
                    START: begin
                        if (sample_now) begin
                            if (rxs) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end else begin
                                state   <= DATA;
                                bit_cnt <= '0;
                            end
                        end
                    end
                    DATA: begin
                        if (sample_now) begin
                            shift_q[bit_cnt] <= rxs;
                            ones_q           <= ones_q ^ rxs;
                            bit_cnt          <= bit_cnt + 3'd1;
                            // last data bit is index 6 in 7-bit mode, 7 in 8-bit mode
                            if (bit_cnt == {2'b11, cfg_dl}) begin
                                state <= (cfg_p[0] ^ cfg_p[1]) ? PARITY : STOP1;
                            end
                        end
                    end
                    PARITY: begin
                        if (sample_now) begin
                            par_flag <= (cfg_p == 2'b01) ? ~(ones_q ^ rxs) : (ones_q ^ rxs);
                            state    <= STOP1;
                        end
                    end
                    STOP1: begin
                        if (sample_now) begin
                            if (!rxs) begin
                                frm_flag <= 1'b1;
                            end
                            state <= cfg_s ? STOP2 : DONE;
                        end
                    end
                    STOP2: begin
                        if (sample_now) begin
                            if (!rxs) begin
                                frm_flag <= 1'b1;
                            end
                            state <= DONE;
                        end
                    end
                    DONE: begin
                        rx_data    <= shift_q;
                        parity_err <= par_flag;
                        frame_err  <= frm_flag;
                        rx_valid   <= 1'b1;
                        state      <= IDLE;
                        busy       <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_deframer.sv
// tb/tb_uart_rx_deframer.sv - self-checking bench for uart_rx_deframer
module tb_uart_rx_deframer;
    localparam int OS  = 16;
    localparam int DIV = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       sample_tick;
    logic       rx_en;
    logic       rxd;
    logic       dL;
    logic [1:0] p;
    logic       s;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    uart_rx_deframer #(.OVERSAMPLE(OS), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .sample_tick(sample_tick), .rx_en(rx_en), .rxd(rxd),
        .dL(dL), .p(p), .s(s), .rx_data(rx_data), .rx_valid(rx_valid),
        .parity_err(parity_err), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       pe;
        logic       fe;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        logic       dl;
        logic [1:0] pm;
        logic       sb;
        logic       pb;
        logic       st1;
        logic       st2;
        logic [7:0] e_data;
        logic       e_pe;
        logic       e_fe;
    } vec_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   phase = 0;
    int   valid_seen = 0;
    logic prev_valid = 1'b0;
    int   busy_ticks = 0;
    int   busy_at_valid = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_near(input string name, input int act, input int exp, input int tol);
        n_vec++;
        if (act < exp - tol || act > exp + tol) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d +/- %0d", name, act, exp, tol);
        end
    endtask

    // one clock: observe outputs mid-cycle, then set up the tick for the next edge
    task automatic step();
        exp_t e;
        @(negedge clk);
        if (rx_valid) begin
            valid_seen++;
            busy_at_valid = busy_ticks;
            check("rx_valid_one_clk", prev_valid, 1'b0);
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_rx_valid: got rx_data 0x%0h with no frame outstanding", rx_data);
            end else begin
                e = exp_q.pop_front();
                check("rx_data", rx_data, e.data);
                check("parity_err", parity_err, e.pe);
                check("frame_err", frame_err, e.fe);
            end
        end
        prev_valid = rx_valid;
        if (sample_tick && busy) busy_ticks++;
        phase = (phase + 1) % DIV;
        sample_tick = (phase == 0);
    endtask

    task automatic wait_ticks(input int n);
        int c = 0;
        while (c < n) begin
            step();
            if (sample_tick) c++;
        end
    endtask

    task automatic send_bit(input logic b);
        rxd = b;
        wait_ticks(OS);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic dl, input logic [1:0] pm, input logic sb,
                              input logic pb, input logic st1, input logic st2);
        dL = dl; p = pm; s = sb;
        send_bit(1'b0);
        dL = 1'($urandom); p = 2'($urandom); s = 1'($urandom);
        for (int i = 0; i < (dl ? 8 : 7); i++) send_bit(d[i]);
        if (pm == 2'b01 || pm == 2'b10) send_bit(pb);
        send_bit(st1);
        if (sb) send_bit(st2);
        rxd = 1'b1;
    endtask

    task automatic send_partial(input logic [7:0] d);
        dL = 1'b1; p = 2'b00; s = 1'b0;
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(d[i]);
        rxd = d[3];
        wait_ticks(OS / 2);
    endtask

    function automatic exp_t model(input logic [7:0] d, input logic dl, input logic [1:0] pm,
                                   input logic sb, input logic pb, input logic st1, input logic st2);
        exp_t e;
        logic [7:0] m;
        int ones;
        m = dl ? d : {1'b0, d[6:0]};
        ones = $countones(m) + int'(pb);
        e.data = m;
        if (pm == 2'b01) e.pe = (ones % 2 == 0);
        else if (pm == 2'b10) e.pe = (ones % 2 == 1);
        else e.pe = 1'b0;
        e.fe = !st1 || (sb && !st2);
        return e;
    endfunction

    function automatic int frame_busy_ticks(input logic dl, input logic [1:0] pm, input logic sb);
        int nbits;
        nbits = (dl ? 8 : 7) + ((pm == 2'b01 || pm == 2'b10) ? 1 : 0) + 1 + int'(sb);
        return OS / 2 + OS * nbits;
    endfunction

    localparam int NV = 9;
    vec_t tbl[NV];

    initial begin
        int v0;
        logic [7:0] rd;
        logic rdl, rsb, rpb, rs1, rs2;
        logic [1:0] rpm;
        int gap;

        tbl[0] = '{8'hAB, 1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 8'hAB, 1'b0, 1'b0};
        tbl[1] = '{8'h2B, 1'b0, 2'b10, 1'b1, 1'b0, 1'b1, 1'b1, 8'h2B, 1'b0, 1'b0};
        tbl[2] = '{8'hAB, 1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 8'hAB, 1'b1, 1'b0};
        tbl[3] = '{8'h6D, 1'b0, 2'b11, 1'b1, 1'b0, 1'b1, 1'b0, 8'h6D, 1'b0, 1'b1};
        tbl[4] = '{8'h00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0};
        tbl[5] = '{8'hFF, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 8'h7F, 1'b0, 1'b0};
        tbl[6] = '{8'h81, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 8'h81, 1'b0, 1'b1};
        tbl[7] = '{8'h00, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
        tbl[8] = '{8'h01, 1'b1, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0};

        rst = 1'b1; rx_en = 1'b1; rxd = 1'b1; dL = 1'b1; p = 2'b00; s = 1'b0; sample_tick = 1'b0;
        repeat (4) step();
        rst = 1'b0;
        step();
        check("reset_rx_data", rx_data, 8'h00);
        check("reset_rx_valid", rx_valid, 1'b0);
        check("reset_parity_err", parity_err, 1'b0);
        check("reset_frame_err", frame_err, 1'b0);
        check("reset_busy", busy, 1'b0);
        wait_ticks(20);

        for (int i = 0; i < NV; i++) begin
            exp_q.push_back('{tbl[i].e_data, tbl[i].e_pe, tbl[i].e_fe});
            busy_ticks = 0;
            v0 = valid_seen;
            send_frame(tbl[i].data, tbl[i].dl, tbl[i].pm, tbl[i].sb, tbl[i].pb, tbl[i].st1, tbl[i].st2);
            wait_ticks(24);
            check("tbl_valid_count", valid_seen - v0, 1);
            check_near("tbl_busy_span", busy_at_valid, frame_busy_ticks(tbl[i].dl, tbl[i].pm, tbl[i].sb), 2);
        end

        // short low glitch is a false start, then a clean 8N1 frame
        v0 = valid_seen;
        rxd = 1'b0;
        wait_ticks(OS / 4);
        rxd = 1'b1;
        wait_ticks(20);
        check("glitch_no_valid", valid_seen - v0, 0);
        check("glitch_busy", busy, 1'b0);
        exp_q.push_back('{8'hFF, 1'b0, 1'b0});
        send_frame(8'hFF, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
        wait_ticks(24);
        check("glitch_next_frame", exp_q.size(), 0);

        // rx_en dropped during data bit 3
        v0 = valid_seen;
        send_partial(8'h00);
        rx_en = 1'b0;
        step();
        check("rxen_abort_busy", busy, 1'b0);
        check("rxen_keeps_rx_data", rx_data, 8'hFF);
        rxd = 1'b1;
        wait_ticks(8);
        rx_en = 1'b1;
        wait_ticks(40);
        check("rxen_abort_no_valid", valid_seen - v0, 0);
        exp_q.push_back('{8'h00, 1'b0, 1'b0});
        send_frame(8'h00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
        wait_ticks(24);
        check("rxen_next_frame", exp_q.size(), 0);

        // load nonzero outputs, then reset during data bit 3
        exp_q.push_back('{8'h5A, 1'b0, 1'b1});
        send_frame(8'h5A, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_ticks(40);
        v0 = valid_seen;
        send_partial(8'h00);
        rst = 1'b1;
        rxd = 1'b1;
        step();
        rst = 1'b0;
        check("rst_abort_busy", busy, 1'b0);
        check("rst_clears_rx_data", rx_data, 8'h00);
        check("rst_clears_frame_err", frame_err, 1'b0);
        check("rst_clears_parity_err", parity_err, 1'b0);
        wait_ticks(40);
        check("rst_abort_no_valid", valid_seen - v0, 0);
        exp_q.push_back('{8'h00, 1'b0, 1'b0});
        send_frame(8'h00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
        wait_ticks(24);
        check("rst_next_frame", exp_q.size(), 0);

        // randomized frames against the reference model
        v0 = valid_seen;
        for (int k = 0; k < 30; k++) begin
            rd  = 8'($urandom);
            rdl = 1'($urandom);
            rpm = 2'($urandom);
            rsb = 1'($urandom);
            rpb = 1'($urandom);
            rs1 = ($urandom_range(0, 9) != 0);
            rs2 = ($urandom_range(0, 9) != 0);
            exp_q.push_back(model(rd, rdl, rpm, rsb, rpb, rs1, rs2));
            send_frame(rd, rdl, rpm, rsb, rpb, rs1, rs2);
            if ((rsb && !rs2) || (!rsb && !rs1)) gap = 24 + int'($urandom_range(0, 8));
            else gap = int'($urandom_range(0, 20));
            if (gap > 0) wait_ticks(gap);
        end
        wait_ticks(40);
        check("random_all_received", exp_q.size(), 0);
        check("random_valid_count", valid_seen - v0, 30);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
